// File: rtl/offnariscv_pkg.sv
// Shared types and constants for the load/store writeback stage.
package offnariscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] rdata;
    logic            is_load;
    logic            trap;
    logic [4:0]      cause;
  } lsuwb_tdata_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            is_load;
    logic            trap;
    logic [4:0]      cause;
  } wbcm_tdata_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style valid/ready channel.
interface axis_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/load_align.sv
// Load data alignment/extension plus misalignment and illegal-width detection.
module load_align
  import offnariscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign,
  output logic            o_illegal
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data     = '0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      F3_LH: begin
        o_data     = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
        o_misalign = i_addr_lo[0];
      end
      F3_LW: begin
        o_data     = w_sh;
        o_misalign = (i_addr_lo != 2'b00);
      end
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      F3_LHU: begin
        o_data     = {{(XLEN-16){1'b0}}, w_sh[15:0]};
        o_misalign = i_addr_lo[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// LSU writeback: 2-entry skid FIFO, load alignment, trap tagging and
// register-file write for retiring loads.
module lsu_writeback
  import offnariscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.slave           lsuwb_axis_if,
  axis_if.master          wbcm_axis_if,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     ld_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  lsuwb_tdata_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_ld_count;

  logic             w_tready;
  logic             w_tvalid;
  logic             w_push;
  logic             w_pop;
  logic             w_we;
  logic             w_ld_inc;
  logic [CNT_W-1:0] w_count_nxt;
  lsuwb_tdata_t     w_head;
  wbcm_tdata_t      w_out;
  logic [XLEN-1:0]  w_al_data;
  logic             w_misalign;
  logic             w_illegal;

  assign w_tready = rst && (r_count != CNT_W'(DEPTH));
  assign w_tvalid = (r_count != '0);
  assign w_push   = lsuwb_axis_if.tvalid && w_tready && !flush;
  assign w_pop    = w_tvalid && wbcm_axis_if.tready;
  assign w_head   = r_mem[r_rptr];

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_funct3   (w_head.funct3),
    .i_addr_lo  (w_head.addr_lo),
    .i_rdata    (w_head.rdata),
    .o_data     (w_al_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // An incoming trap wins over anything detected here.
  always_comb begin
    w_out         = '0;
    w_out.rd      = w_head.rd;
    w_out.is_load = w_head.is_load;
    w_out.trap    = w_head.trap;
    w_out.cause   = w_head.cause;
    if (!w_head.trap && w_head.is_load) begin
      if (w_illegal) begin
        w_out.trap  = 1'b1;
        w_out.cause = CAUSE_ILLEGAL;
      end else if (w_misalign) begin
        w_out.trap  = 1'b1;
        w_out.cause = CAUSE_LD_MISALIGN;
      end else begin
        w_out.data = w_al_data;
      end
    end
  end

  assign w_ld_inc = w_pop && w_out.is_load && !w_out.trap && !flush;
  assign w_we     = w_ld_inc && (w_out.rd != 5'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ld_count <= '0;
    end else begin
      if (flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      end
      if (w_ld_inc) r_ld_count <= r_ld_count + 32'd1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= lsuwb_tdata_t'(lsuwb_axis_if.tdata);
  end

  assign lsuwb_axis_if.tready = w_tready;
  assign wbcm_axis_if.tvalid  = w_tvalid;
  assign wbcm_axis_if.tdata   = w_out;
  assign rf_we                = w_we;
  assign rf_waddr             = w_we ? w_out.rd : 5'd0;
  assign rf_wdata             = w_we ? w_out.data : '0;
  assign ld_count             = r_ld_count;

endmodule

// File: tb/tb_lsu_writeback.sv
// Scoreboard bench for lsu_writeback: expected retire records queued on accept.
module tb_lsu_writeback;
  import offnariscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] ld_count;

  axis_if #(.DATA_W($bits(lsuwb_tdata_t))) lsuwb_if ();
  axis_if #(.DATA_W($bits(wbcm_tdata_t)))  wbcm_if ();

  lsu_writeback #(.XLEN(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .lsuwb_axis_if (lsuwb_if),
    .wbcm_axis_if  (wbcm_if),
    .flush         (flush),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .ld_count      (ld_count)
  );

  always #5 clk = ~clk;

  int          n_tot = 0;
  int          n_bad = 0;
  int          n_we = 0;
  int          n_ret = 0;
  wbcm_tdata_t q [$];
  logic [31:0] exp_ld = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [4:0]  last_waddr = 5'd0;
  wbcm_tdata_t last_rec = '0;
  logic        prev_stall = 1'b0;
  logic [$bits(wbcm_tdata_t)-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic lsuwb_tdata_t mk(input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [1:0] a, input logic [31:0] d,
                                      input logic ld, input logic tr, input logic [4:0] c);
    lsuwb_tdata_t b;
    b.rd = rd; b.funct3 = f3; b.addr_lo = a; b.rdata = d;
    b.is_load = ld; b.trap = tr; b.cause = c;
    return b;
  endfunction

  function automatic wbcm_tdata_t exp_rec(input lsuwb_tdata_t b);
    wbcm_tdata_t r;
    logic [31:0] sh;
    r = '0;
    r.rd = b.rd; r.is_load = b.is_load; r.trap = b.trap; r.cause = b.cause;
    sh = b.rdata >> {b.addr_lo, 3'b000};
    if (b.is_load && !b.trap) begin
      case (b.funct3)
        3'b000: r.data = {{24{sh[7]}}, sh[7:0]};
        3'b100: r.data = {24'd0, sh[7:0]};
        3'b001, 3'b101: begin
          if (b.addr_lo[0]) begin r.trap = 1'b1; r.cause = 5'd4; end
          else if (b.funct3[2]) r.data = {16'd0, sh[15:0]};
          else r.data = {{16{sh[15]}}, sh[15:0]};
        end
        3'b010: begin
          if (b.addr_lo != 2'd0) begin r.trap = 1'b1; r.cause = 5'd4; end
          else r.data = b.rdata;
        end
        default: begin r.trap = 1'b1; r.cause = 5'd2; end
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    wbcm_tdata_t obs;
    wbcm_tdata_t e;
    logic        ewe;
    obs = wbcm_tdata_t'(wbcm_if.tdata);
    if (!rst) begin
      check("rst_vld", 64'(wbcm_if.tvalid), 64'd0);
      check("rst_rdy", 64'(lsuwb_if.tready), 64'd0);
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_waddr", 64'(rf_waddr), 64'd0);
      check("rst_wdata", 64'(rf_wdata), 64'd0);
      check("rst_ldcnt", 64'(ld_count), 64'd0);
      q.delete();
      exp_ld = 32'd0;
      prev_stall = 1'b0;
    end else begin
      check("vld", 64'(wbcm_if.tvalid), 64'(q.size() != 0));
      check("rdy", 64'(lsuwb_if.tready), 64'(q.size() < 2));
      check("ldcnt", 64'(ld_count), 64'(exp_ld));
      if (prev_stall) check("hold", 64'(wbcm_if.tdata), 64'(prev_data));
      if (rf_we) begin
        n_we++;
        last_wdata = rf_wdata;
        last_waddr = rf_waddr;
      end
      if (wbcm_if.tvalid && wbcm_if.tready) begin
        if (q.size() == 0) begin
          check("pop_empty", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          if (e.trap) begin e.data = '0; obs.data = '0; end
          check("rec", 64'(obs), 64'(e));
          ewe = e.is_load && !e.trap && (e.rd != 5'd0) && !flush;
          check("we", 64'(rf_we), 64'(ewe));
          if (ewe) begin
            check("waddr", 64'(rf_waddr), 64'(e.rd));
            check("wdata", 64'(rf_wdata), 64'(e.data));
          end
          if (e.is_load && !e.trap && !flush) exp_ld = exp_ld + 32'd1;
          last_rec = wbcm_tdata_t'(wbcm_if.tdata);
          n_ret++;
        end
      end else begin
        check("we_idle", 64'(rf_we), 64'd0);
      end
      if (lsuwb_if.tvalid && lsuwb_if.tready && !flush)
        q.push_back(exp_rec(lsuwb_tdata_t'(lsuwb_if.tdata)));
      if (flush) q.delete();
      prev_stall = wbcm_if.tvalid && !wbcm_if.tready && !flush;
      prev_data  = wbcm_if.tdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input lsuwb_tdata_t b);
    int n = 0;
    lsuwb_if.tvalid = 1'b1;
    lsuwb_if.tdata  = b;
    @(negedge clk);
    while (!lsuwb_if.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'd1, 64'd0);
    step();
    lsuwb_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'd1, 64'd0);
    step();
  endtask

  logic [31:0] saved_ld;
  int          saved_we;
  int          saved_ret;

  initial begin
    lsuwb_if.tvalid = 1'b0;
    lsuwb_if.tdata  = '0;
    wbcm_if.tready  = 1'b0;
    repeat (3) step();
    check("rst_hold_rdy", 64'(lsuwb_if.tready), 64'd0);
    rst = 1'b1;
    #1;
    check("rdy_after_rst", 64'(lsuwb_if.tready), 64'd1);
    step();

    // Aligned loads and local traps
    wbcm_if.tready = 1'b1;
    send(mk(5'd5, 3'b000, 2'd3, 32'h80FF_FF12, 1'b1, 1'b0, 5'd0));
    drain();
    check("lb_wdata", 64'(last_wdata), 64'hFFFF_FF80);
    check("lb_waddr", 64'(last_waddr), 64'd5);
    check("lb_ldcnt", 64'(ld_count), 64'd1);
    send(mk(5'd6, 3'b101, 2'd2, 32'hBEEF_0000, 1'b1, 1'b0, 5'd0));
    drain();
    check("lhu_wdata", 64'(last_wdata), 64'h0000_BEEF);
    send(mk(5'd7, 3'b010, 2'd1, 32'h1234_5678, 1'b1, 1'b0, 5'd0));
    drain();
    check("lw_mis_trap", 64'(last_rec.trap), 64'd1);
    check("lw_mis_cause", 64'(last_rec.cause), 64'd4);
    check("lw_mis_we", 64'(n_we), 64'd2);
    send(mk(5'd8, 3'b001, 2'd2, 32'h8001_0000, 1'b1, 1'b0, 5'd0));
    send(mk(5'd9, 3'b110, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0));
    send(mk(5'd10, 3'b010, 2'd1, 32'h0, 1'b1, 1'b1, 5'd5));
    drain();
    check("lh_wdata", 64'(last_wdata), 64'hFFFF_8001);
    check("passthru_cause", 64'(last_rec.cause), 64'd5);
    check("ldcnt_after_traps", 64'(ld_count), 64'd3);

    // Backpressure: three beats offered, two fit
    wbcm_if.tready = 1'b0;
    saved_ret = n_ret;
    fork
      begin
        send(mk(5'd11, 3'b100, 2'd1, 32'h0000_AB00, 1'b1, 1'b0, 5'd0));
        send(mk(5'd12, 3'b000, 2'd0, 32'h0000_007F, 1'b1, 1'b0, 5'd0));
        send(mk(5'd13, 3'b010, 2'd0, 32'hCAFE_F00D, 1'b1, 1'b0, 5'd0));
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_rdy", 64'(lsuwb_if.tready), 64'd0);
        check("bp_vld", 64'(wbcm_if.tvalid), 64'd1);
        step();
        wbcm_if.tready = 1'b1;
      end
    join
    drain();
    check("bp_retired", 64'(n_ret - saved_ret), 64'd3);
    check("bp_last", 64'(last_wdata), 64'hCAFE_F00D);

    // Flush while full with a retire handshake in the same cycle
    wbcm_if.tready = 1'b0;
    send(mk(5'd14, 3'b010, 2'd0, 32'h1111_1111, 1'b1, 1'b0, 5'd0));
    send(mk(5'd15, 3'b010, 2'd0, 32'h2222_2222, 1'b1, 1'b0, 5'd0));
    saved_ld = ld_count;
    saved_we = n_we;
    flush = 1'b1;
    wbcm_if.tready = 1'b1;
    step();
    flush = 1'b0;
    wbcm_if.tready = 1'b0;
    check("fl_vld", 64'(wbcm_if.tvalid), 64'd0);
    check("fl_ldcnt", 64'(ld_count), 64'(saved_ld));
    check("fl_we", 64'(n_we), 64'(saved_we));

    // Flush drops a beat accepted in the same cycle
    send(mk(5'd16, 3'b010, 2'd0, 32'h3333_3333, 1'b1, 1'b0, 5'd0));
    lsuwb_if.tvalid = 1'b1;
    lsuwb_if.tdata  = mk(5'd17, 3'b010, 2'd0, 32'h4444_4444, 1'b1, 1'b0, 5'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    lsuwb_if.tvalid = 1'b0;
    check("fl2_vld", 64'(wbcm_if.tvalid), 64'd0);
    wbcm_if.tready = 1'b1;
    repeat (3) step();
    check("fl2_we", 64'(n_we), 64'(saved_we));

    // rd=0 load counts but does not write; store retires with zero data
    saved_ld = ld_count;
    send(mk(5'd0, 3'b010, 2'd0, 32'h5555_5555, 1'b1, 1'b0, 5'd0));
    drain();
    check("rd0_ldcnt", 64'(ld_count), 64'(saved_ld + 32'd1));
    check("rd0_we", 64'(n_we), 64'(saved_we));
    send(mk(5'd18, 3'b010, 2'd0, 32'h1234_5678, 1'b0, 1'b0, 5'd0));
    drain();
    check("st_data", 64'(last_rec.data), 64'd0);
    check("st_ldcnt", 64'(ld_count), 64'(saved_ld + 32'd1));
    check("st_we", 64'(n_we), 64'(saved_we));

    // Reset mid-operation with one beat buffered
    wbcm_if.tready = 1'b0;
    send(mk(5'd19, 3'b010, 2'd0, 32'h6666_6666, 1'b1, 1'b0, 5'd0));
    check("pre_rst_vld", 64'(wbcm_if.tvalid), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_vld", 64'(wbcm_if.tvalid), 64'd0);
    check("mid_rst_ldcnt", 64'(ld_count), 64'd0);
    check("mid_rst_rdy", 64'(lsuwb_if.tready), 64'd0);
    repeat (2) step();
    rst = 1'b1;
    wbcm_if.tready = 1'b1;
    step();
    send(mk(5'd9, 3'b000, 2'd1, 32'h0000_7F00, 1'b1, 1'b0, 5'd0));
    drain();
    check("post_rst_wdata", 64'(last_wdata), 64'h0000_007F);
    check("post_rst_waddr", 64'(last_waddr), 64'd9);
    check("post_rst_ldcnt", 64'(ld_count), 64'd1);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_writeback.md
LSU_WRITEBACK -- requirements
Module: lsu_writeback

Interface
REQ-001 SHALL have parameter: XLEN, 32, data width of the register file.
REQ-002 SHALL have parameter: DEPTH, 2, number of entries in the input buffer; fixed at 2 for this revision.
REQ-003 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: lsuwb_axis_if  slave axis_if  $bits(lsuwb_tdata_t)  load/store results from the LSU.
REQ-006 SHALL have port: wbcm_axis_if  master axis_if  $bits(wbcm_tdata_t)  retire records to the commit stage.
REQ-007 SHALL have port: flush  input  1  synchronous pipeline flush request.
REQ-008 SHALL have port: rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-009 SHALL have port: rf_waddr  output  5  register-file destination index.
REQ-010 SHALL have port: rf_wdata  output  XLEN  register-file write data.
REQ-011 SHALL have port: ld_count  output  32  count of retired, non-trapping loads.

Function
REQ-012 SHALL buffer accepted lsuwb beats in a DEPTH-entry FIFO; lsuwb tready = (count != DEPTH) and rst high, derived from registers only, with no combinational path from wbcm tready.
REQ-013 SHALL drive wbcm tvalid = (count != 0); tdata is computed combinationally from the FIFO head; latency from lsuwb handshake to wbcm tvalid is 1 cycle.
REQ-014 SHALL hold wbcm tvalid and tdata stable until the wbcm handshake.
REQ-015 SHALL align the load data as follows: shift rdata right by 8*addr_lo; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the data unchanged.
REQ-016 SHALL flag a misaligned load, i.e. LH/LHU with addr_lo[0]=1 or LW with addr_lo!=0, as trap=1 with cause=4.
REQ-017 SHALL flag a load with funct3 of 011, 110 or 111 as trap=1 with cause=2.
REQ-018 SHALL pass the incoming trap and cause through unchanged when the beat already carries trap=1; that value takes priority over REQ-016 and REQ-017.
REQ-019 SHALL pass store beats (is_load=0) to wbcm with data=0 and never write the register file for them.
REQ-020 SHALL assert rf_we only in a cycle with a wbcm handshake, is_load=1, trap=0, rd!=0 and flush=0; rf_waddr and rf_wdata take the head values in that cycle.
REQ-021 SHALL keep count unchanged on a simultaneous push and pop at count 1; when full, push is impossible and pop frees a slot visible on the next cycle.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL, on flush=1, clear count and both pointers at the next edge, discard any lsuwb beat handshaked in the same cycle, and suppress rf_we and ld_count update in that cycle.
REQ-024 SHALL increment ld_count on each rf_we-qualifying handshake, including loads to rd=0; it wraps from 0xFFFF_FFFF to 0.

Reset
REQ-025 SHALL, while rst=0, hold count=0, pointers=0, wbcm tvalid=0, lsuwb tready=0, rf_we=0, rf_waddr=0, rf_wdata=0 and ld_count=0.
REQ-026 SHALL, when reset is asserted mid-operation, drop all buffered beats immediately; lsuwb tready rises in the first cycle after rst deasserts.

Structure
REQ-027 SHALL take lsuwb_tdata_t {rd[4:0], funct3[2:0], addr_lo[1:0], rdata[XLEN-1:0], is_load, trap, cause[4:0]} from offnariscv_pkg.
REQ-028 SHALL take wbcm_tdata_t {rd, data, is_load, trap, cause} from offnariscv_pkg.
REQ-029 SHALL take the cause constants CAUSE_ILLEGAL=2 and CAUSE_LD_MISALIGN=4 from offnariscv_pkg.
REQ-030 SHALL implement the load alignment and extension as one combinational sub-module, load_align; the FIFO is inline.

Verification
REQ-031 SHALL cover: LB rd=5, addr_lo=3, rdata=0x80FF_FF12 -> rf_we, rf_waddr=5, rf_wdata=0xFFFF_FF80, ld_count=1.
REQ-032 SHALL cover: LHU addr_lo=2, rdata=0xBEEF_0000 -> rf_wdata=0x0000_BEEF; LW addr_lo=1 -> wbcm trap=1, cause=4, rf_we=0.
REQ-033 SHALL cover: wbcm tready=0 while three beats are offered -> lsuwb tready=0 after two accepts; release -> three retire in order, none lost.
REQ-034 SHALL cover: flush asserted with count=2 and a handshake in the same cycle -> next cycle tvalid=0, no rf_we, ld_count unchanged.
REQ-035 SHALL cover: LW rd=0 -> rf_we=0 and ld_count increments; a store beat -> wbcm data=0 and rf_we=0.
REQ-036 SHALL cover: rst pulled low with count=1 -> tvalid=0 immediately, all outputs 0; after release the first new beat retires correctly.
